// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth multiplier
package booth_pkg;

    localparam int BOOTH_WIDTH_DEF = 8;

    // Step counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    localparam int BOOTH_CNT_W_DEF = $clog2(BOOTH_WIDTH_DEF + 1);

    function automatic int booth_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_M = 3'd1,
        ST_LOAD_Q = 3'd2,
        ST_CALC   = 3'd3,
        ST_OUT_HI = 3'd4,
        ST_OUT_LO = 3'd5
    } booth_state_e;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth step (add/sub then arithmetic shift)
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH_DEF
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH:0]   m_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q1_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q1_o
);

    logic [WIDTH:0] sum;

    // Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M, otherwise keep A.
    always_comb begin
        sum = a_i;
        case ({q_i[0], q1_i})
            2'b01:   sum = a_i + m_i;
            2'b10:   sum = a_i - m_i;
            default: sum = a_i;
        endcase
    end

    // Arithmetic right shift of {A, Q, q_1}; A's MSB is replicated.
    assign a_o  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_o  = {sum[0], q_i[WIDTH-1:1]};
    assign q1_o = q_i[0];

endmodule

// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - sequential signed Booth multiplier with byte-wide load and readout
module booth_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beginsig,
    input  logic             locksig,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             endsig
);

    localparam int CW = booth_cnt_width(WIDTH);

    booth_state_e   state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] outbus_q, outbus_d;
    logic             endsig_q, endsig_d;

    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic             q1_step;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i  (a_q),
        .m_i  (m_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .a_o  (a_step),
        .q_o  (q_step),
        .q1_o (q1_step)
    );

    // State register and datapath; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            cnt_q    <= '0;
            outbus_q <= '0;
            endsig_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            m_q      <= m_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            cnt_q    <= cnt_d;
            outbus_q <= outbus_d;
            endsig_q <= endsig_d;
        end
    end

    // Next-state and datapath updates; beginsig outside IDLE restarts at LOAD_M.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        m_d      = m_q;
        q_d      = q_q;
        q1_d     = q1_q;
        cnt_d    = cnt_q;
        outbus_d = outbus_q;
        endsig_d = 1'b0;

        if (state_q != ST_IDLE && beginsig) begin
            // Held beginsig parks in LOAD_M, but M is still captured when qualified.
            state_d = ST_LOAD_M;
            if (state_q == ST_LOAD_M && locksig) begin
                m_d  = {inbus[WIDTH-1], inbus};
                a_d  = '0;
                q1_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (beginsig) begin
                        state_d = ST_LOAD_M;
                    end
                end
                ST_LOAD_M: begin
                    if (locksig) begin
                        m_d     = {inbus[WIDTH-1], inbus};
                        a_d     = '0;
                        q1_d    = 1'b0;
                        state_d = ST_LOAD_Q;
                    end
                end
                ST_LOAD_Q: begin
                    if (locksig) begin
                        q_d     = inbus;
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    a_d   = a_step;
                    q_d   = q_step;
                    q1_d  = q1_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_OUT_HI;
                    end
                end
                ST_OUT_HI: begin
                    outbus_d = a_q[WIDTH-1:0];
                    endsig_d = 1'b1;
                    state_d  = ST_OUT_LO;
                end
                ST_OUT_LO: begin
                    outbus_d = q_q;
                    endsig_d = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign outbus = outbus_q;
    assign endsig = endsig_q;

endmodule

// File: tb/tb_booth_mult.sv
// tb/tb_booth_mult.sv - directed self-checking bench for booth_mult
module tb_booth_mult;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       beginsig;
    logic       locksig;
    logic [7:0] inbus;
    logic [7:0] outbus;
    logic       endsig;

    int total = 0;
    int bad   = 0;

    logic       chk_en  = 1'b0;
    logic [7:0] exp_out = 8'h00;
    logic       exp_end = 1'b0;

    booth_mult #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .beginsig (beginsig),
        .locksig  (locksig),
        .inbus    (inbus),
        .outbus   (outbus),
        .endsig   (endsig)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Signed product from plain integer arithmetic.
    function automatic logic [15:0] model(input logic [7:0] m, input logic [7:0] q);
        int a;
        int b;
        int p;
        a = int'($signed(m));
        b = int'($signed(q));
        p = a * b;
        return p[15:0];
    endfunction

    // Per-cycle comparison of the outputs against the expected schedule.
    always @(negedge clk) begin
        if (chk_en) begin
            check("endsig_cycle", {31'd0, endsig}, {31'd0, exp_end});
            check("outbus_cycle", {24'd0, outbus}, {24'd0, exp_out});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] m);
        beginsig = 1'b1;
        locksig  = 1'b1;
        inbus    = m;
        tick();
        beginsig = 1'b0;
    endtask

    // Hold locksig low for 'stall' cycles with junk on inbus, then capture v.
    task automatic load(input logic [7:0] v, input int stall);
        locksig = 1'b0;
        inbus   = 8'h5A;
        repeat (stall) tick();
        locksig = 1'b1;
        inbus   = v;
        tick();
        locksig = 1'b0;
        inbus   = 8'hC3;
    endtask

    // Called right after edge E: eight CALC edges, then two result beats.
    task automatic collect(input string name, input logic [7:0] m, input logic [7:0] q,
                           input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] p;
        p = model(m, q);
        check({name, "_model"}, {16'd0, p}, {16'd0, hi, lo});
        repeat (8) tick();
        tick();
        exp_end = 1'b1;
        exp_out = p[15:8];
        check({name, "_hi"}, {24'd0, outbus}, {24'd0, hi});
        tick();
        exp_out = p[7:0];
        check({name, "_lo"}, {24'd0, outbus}, {24'd0, lo});
        tick();
        exp_end = 1'b0;
    endtask

    task automatic run(input string name, input logic [7:0] m, input logic [7:0] q,
                       input int sm, input int sq, input logic [7:0] hi, input logic [7:0] lo);
        start(m);
        load(m, sm);
        load(q, sq);
        collect(name, m, q, hi, lo);
    endtask

    typedef struct {
        logic [7:0] m;
        logic [7:0] q;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h45, 8'hD3, 8'hF3, 8'hDF};
        vecs[1] = '{8'h7F, 8'h7F, 8'h3F, 8'h01};
        vecs[2] = '{8'h80, 8'h80, 8'h40, 8'h00};
        vecs[3] = '{8'h80, 8'h7F, 8'hC0, 8'h80};
        vecs[4] = '{8'h00, 8'hA5, 8'h00, 8'h00};
        vecs[5] = '{8'hFF, 8'hFF, 8'h00, 8'h01};

        rst_n    = 1'b0;
        beginsig = 1'b0;
        locksig  = 1'b0;
        inbus    = 8'h00;
        #2;
        check("reset_outbus", {24'd0, outbus}, 32'd0);
        check("reset_endsig", {31'd0, endsig}, 32'd0);
        chk_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            run($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, 0, 0, vecs[i].hi, vecs[i].lo);
            tick();
        end

        // Stalled loads: result shifts by exactly the 8 stall cycles.
        run("stall", 8'h45, 8'hD3, 5, 3, 8'hF3, 8'hDF);
        tick();

        // Abort mid-CALC, then a fresh operand load without a second start.
        start(8'h45);
        load(8'h45, 0);
        load(8'hD3, 0);
        repeat (4) tick();
        beginsig = 1'b1;
        tick();
        beginsig = 1'b0;
        load(8'h03, 0);
        load(8'h05, 0);
        collect("abort_calc", 8'h03, 8'h05, 8'h00, 8'h0F);
        tick();

        // Asynchronous reset mid-CALC clears outputs without waiting for an edge.
        start(8'hFF);
        load(8'hFF, 0);
        load(8'hFF, 0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_out = 8'h00;
        exp_end = 1'b0;
        check("async_rst_outbus", {24'd0, outbus}, 32'd0);
        check("async_rst_endsig", {31'd0, endsig}, 32'd0);
        tick();
        rst_n   = 1'b1;
        locksig = 1'b1;
        inbus   = 8'h33;
        repeat (12) tick();
        locksig = 1'b0;

        // Abort while the high byte is on the bus: endsig drops, outbus holds.
        start(8'h7F);
        load(8'h7F, 0);
        load(8'h7F, 0);
        repeat (9) tick();
        exp_end = 1'b1;
        exp_out = 8'h3F;
        beginsig = 1'b1;
        tick();
        beginsig = 1'b0;
        exp_end = 1'b0;
        check("abort_out_endsig", {31'd0, endsig}, 32'd0);
        check("abort_out_outbus", {24'd0, outbus}, 32'h3F);
        load(8'h80, 0);
        load(8'h80, 0);
        collect("after_abort_out", 8'h80, 8'h80, 8'h40, 8'h00);
        tick();

        run("final", 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h01);
        tick();
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
